// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: sync/DE generation, framebuffer pixel fetch and RGB pin drive.
// Run/stop requests take effect only at frame boundaries, so every emitted frame is whole.
module vga_timing_ctrl #(
    parameter int unsigned HORIZ_SYNC         = 96,
    parameter int unsigned HORIZ_BACK_PORCH   = 48,
    parameter int unsigned HORIZ_ACTIVE_WIDTH = 640,
    parameter int unsigned HORIZ_FRONT_PORCH  = 16,
    parameter int unsigned VERT_SYNC          = 2,
    parameter int unsigned VERT_BACK_PORCH    = 33,
    parameter int unsigned VERT_ACTIVE_HEIGHT = 480,
    parameter int unsigned VERT_FRONT_PORCH   = 10,
    parameter int unsigned COLOUR_DEPTH       = 8,
    parameter int unsigned ADDR_W             = 20
) (
    input  logic                      PCLK,
    input  logic                      RST_N,
    input  logic                      ENABLE_IN,
    input  logic [ADDR_W-1:0]         FB_BASE_IN,
    output logic                      PIX_REQ_OUT,
    output logic [ADDR_W-1:0]         PIX_ADDR_OUT,
    input  logic                      PIX_GNT_IN,
    input  logic [3*COLOUR_DEPTH-1:0] PIX_DATA_IN,
    output logic                      HSYNC_OUT,
    output logic                      VSYNC_OUT,
    output logic                      DE_OUT,
    output logic [COLOUR_DEPTH-1:0]   RED_OUT,
    output logic [COLOUR_DEPTH-1:0]   GREEN_OUT,
    output logic [COLOUR_DEPTH-1:0]   BLUE_OUT,
    output logic                      FRAME_START_OUT,
    output logic [15:0]               FRAME_CNT_OUT,
    output logic [15:0]               UNDERRUN_CNT_OUT,
    output logic                      BUSY_OUT
);

    localparam int unsigned HTOTAL = HORIZ_SYNC + HORIZ_BACK_PORCH + HORIZ_ACTIVE_WIDTH
                                   + HORIZ_FRONT_PORCH;
    localparam int unsigned VTOTAL = VERT_SYNC + VERT_BACK_PORCH + VERT_ACTIVE_HEIGHT
                                   + VERT_FRONT_PORCH;
    localparam int unsigned HCW = $clog2(HTOTAL + 1);
    localparam int unsigned VCW = $clog2(VTOTAL + 1);

    localparam logic [HCW-1:0] H_LAST      = HCW'(HTOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_END  = HCW'(HORIZ_SYNC);
    localparam logic [HCW-1:0] H_ACT_START = HCW'(HORIZ_SYNC + HORIZ_BACK_PORCH);
    localparam logic [HCW-1:0] H_ACT_END   = HCW'(HORIZ_SYNC + HORIZ_BACK_PORCH
                                                  + HORIZ_ACTIVE_WIDTH);
    localparam logic [VCW-1:0] V_LAST      = VCW'(VTOTAL - 1);
    localparam logic [VCW-1:0] V_SYNC_END  = VCW'(VERT_SYNC);
    localparam logic [VCW-1:0] V_ACT_START = VCW'(VERT_SYNC + VERT_BACK_PORCH);
    localparam logic [VCW-1:0] V_ACT_END   = VCW'(VERT_SYNC + VERT_BACK_PORCH
                                                  + VERT_ACTIVE_HEIGHT);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

    state_t                    r_state;
    logic [HCW-1:0]            r_h;
    logic [VCW-1:0]            r_v;

    logic                      r_req;
    logic [ADDR_W-1:0]         r_pix_addr;
    logic [ADDR_W-1:0]         r_addr_next;
    logic                      r_hs1;
    logic                      r_vs1;
    logic                      r_fs1;

    logic                      r_hsync;
    logic                      r_vsync;
    logic                      r_de;
    logic                      r_gnt;
    logic                      r_fs;
    logic [15:0]               r_frame_cnt;
    logic [15:0]               r_underrun;
    logic                      r_busy;

    logic                      w_running;
    logic                      w_h_last;
    logic                      w_v_last;
    logic                      w_frame_end;
    logic                      w_origin;
    logic                      w_active;
    logic [3*COLOUR_DEPTH-1:0] w_rgb;

    assign w_running   = (r_state != StIdle);
    assign w_h_last    = (r_h == H_LAST);
    assign w_v_last    = (r_v == V_LAST);
    assign w_frame_end = w_h_last && w_v_last;
    assign w_origin    = w_running && (r_h == '0) && (r_v == '0);
    assign w_active    = w_running && (r_h >= H_ACT_START) && (r_h < H_ACT_END)
                         && (r_v >= V_ACT_START) && (r_v < V_ACT_END);

    // Counters stay at (0,0) while idle; a run request at the last pixel keeps going seamlessly.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (ENABLE_IN) r_state <= StRun;
                end
                StRun, StDrain: begin
                    if (w_h_last) begin
                        r_h <= '0;
                        r_v <= w_v_last ? '0 : r_v + 1'b1;
                    end else begin
                        r_h <= r_h + 1'b1;
                    end
                    if (ENABLE_IN)        r_state <= StRun;
                    else if (w_frame_end) r_state <= StIdle;
                    else                  r_state <= StDrain;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Stage 1: request, address and timing flags for the current counter position.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_req       <= 1'b0;
            r_pix_addr  <= '0;
            r_addr_next <= '0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_fs1       <= 1'b0;
        end else begin
            r_req <= w_active;
            r_hs1 <= !(w_running && (r_h < H_SYNC_END));
            r_vs1 <= !(w_running && (r_v < V_SYNC_END));
            r_fs1 <= w_origin;
            if (w_origin) begin
                r_addr_next <= FB_BASE_IN;
            end else if (w_active) begin
                r_pix_addr  <= r_addr_next;
                r_addr_next <= r_addr_next + 1'b1;
            end
        end
    end

    // Stage 2: pin-aligned outputs and statistics.
    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_de        <= 1'b0;
            r_gnt       <= 1'b0;
            r_fs        <= 1'b0;
            r_frame_cnt <= '0;
            r_underrun  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_hsync <= r_hs1;
            r_vsync <= r_vs1;
            r_de    <= r_req;
            r_gnt   <= r_req && PIX_GNT_IN;
            r_fs    <= r_fs1;
            r_busy  <= w_running;
            if (r_fs1) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_req && !PIX_GNT_IN && (r_underrun != 16'hFFFF)) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

    // Read data lands in the pin cycle itself, so it is gated straight onto the pins.
    assign w_rgb = r_gnt ? PIX_DATA_IN : '0;

    assign PIX_REQ_OUT      = r_req;
    assign PIX_ADDR_OUT     = r_pix_addr;
    assign HSYNC_OUT        = r_hsync;
    assign VSYNC_OUT        = r_vsync;
    assign DE_OUT           = r_de;
    assign RED_OUT          = w_rgb[3*COLOUR_DEPTH-1:2*COLOUR_DEPTH];
    assign GREEN_OUT        = w_rgb[2*COLOUR_DEPTH-1:COLOUR_DEPTH];
    assign BLUE_OUT         = w_rgb[COLOUR_DEPTH-1:0];
    assign FRAME_START_OUT  = r_fs;
    assign FRAME_CNT_OUT    = r_frame_cnt;
    assign UNDERRUN_CNT_OUT = r_underrun;
    assign BUSY_OUT         = r_busy;

endmodule
